// File: rtl/iob_wb2iob_bridge.sv
// rtl/iob_wb2iob_bridge.sv - Wishbone classic slave to IOb-native initiator bridge
// One transaction in flight; a bounded IOb wait ends the Wishbone cycle with wb_err_o.
module iob_wb2iob_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024,
  parameter int TIMEOUT_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] LAST_CNT = (TIMEOUT == 0) ? '0 : TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-3:0]     r_adr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_we;
  logic                  r_valid;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic [TIMEOUT_W-1:0]  r_cnt;

  logic w_start;
  logic w_issue;
  logic w_release;
  logic w_capture;
  logic w_err;
  logic w_unused_adr;

  // The IOb address is word aligned, so the byte offset is never forwarded.
  assign w_unused_adr = ^wb_adr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_issue   = 1'b0;
    w_release = 1'b0;
    w_capture = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          w_start = 1'b1;
          if (wb_we_i && (wb_sel_i == '0)) begin
            w_next = ST_ACK;
          end else begin
            w_next  = ST_REQ;
            w_issue = 1'b1;
          end
        end
      end
      ST_REQ: begin
        // m_ready beats both an abandoned cycle and an expiring timeout.
        if (m_ready) begin
          w_release = 1'b1;
          if (wb_cyc_i) begin
            w_next    = ST_ACK;
            w_capture = !r_we;
          end else begin
            w_next = ST_IDLE;
          end
        end else if (!wb_cyc_i) begin
          w_next = ST_DRAIN;
        end else if ((TIMEOUT != 0) && (r_cnt == LAST_CNT)) begin
          w_next = ST_DRAIN;
          w_err  = 1'b1;
        end
      end
      ST_ACK: begin
        w_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (m_ready) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
      r_valid <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_start) begin
        r_adr   <= wb_adr_i[ADDR_W-1:2];
        r_wdata <= wb_dat_i;
        r_wstrb <= wb_we_i ? wb_sel_i : '0;
        r_we    <= wb_we_i;
      end
      if (w_issue) begin
        r_valid <= 1'b1;
      end else if (w_release) begin
        r_valid <= 1'b0;
      end
      r_ack <= (w_next == ST_ACK);
      r_err <= w_err;
      if (w_capture) begin
        r_rdata <= m_rdata;
      end
      if (w_next == ST_IDLE) begin
        r_cnt <= '0;
      end else if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign m_valid   = r_valid;
  assign m_address = {r_adr, 2'b00};
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign wb_dat_o  = r_rdata;
  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule
